pcm_rx_sequencer: RTL and testbench

PCM_RX_SEQUENCER -- requirements
Module: pcm_rx_sequencer

---
 rtl/pcm_rx_sequencer.sv | 129 ++++++++++++
 tb/tb_pcm_rx_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_rx_sequencer.sv
// Serial PCM receiver: hunts for a sync byte, assembles FRAME_LEN code bytes,
// hands each to an external expander and buffers the expanded samples in a FIFO.
module pcm_rx_sequencer #(
    parameter logic [7:0] SYNC_WORD  = 8'h7E,
    parameter int         FRAME_LEN  = 4,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] exp_code,
    input  logic [7:0] exp_sample,
    output logic [7:0] sample_data,
    output logic       sample_valid,
    input  logic       sample_ready,
    output logic       sync_lock,
    output logic       frame_done,
    output logic       overflow
);
    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  FRAME_LEN_C = 8'(FRAME_LEN);
    localparam logic [AW:0] DEPTH_C     = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0] CNT_ONE     = (AW+1)'(1);

    typedef enum logic {HUNT = 1'b0, LOAD = 1'b1} state_e;

    state_e        state_q;
    logic [7:0]    win_q, win_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    byte_cnt_q, byte_cnt_d;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    exp_code_q;
    logic          wr_pend_q;
    logic          sync_lock_q;
    logic          frame_done_q;
    logic          overflow_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          fifo_full, do_pop, do_push;

    always_comb begin
        win_d      = {win_q[6:0], bit_in};
        shreg_d    = {shreg_q[6:0], bit_in};
        byte_cnt_d = byte_cnt_q + 8'd1;
        fifo_full  = (count_q == DEPTH_C);
        do_pop     = (count_q != '0) && sample_ready;
        // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
        do_push    = wr_pend_q && (!fifo_full || do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            win_q        <= 8'h00;
            shreg_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= 8'd0;
            exp_code_q   <= 8'h00;
            wr_pend_q    <= 1'b0;
            sync_lock_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            wr_pend_q    <= 1'b0;
            frame_done_q <= 1'b0;
            if (bit_valid) begin
                case (state_q)
                    HUNT: begin
                        win_q <= win_d;
                        if (win_d == SYNC_WORD) begin
                            state_q     <= LOAD;
                            sync_lock_q <= 1'b1;
                            bit_cnt_q   <= 3'd0;
                            byte_cnt_q  <= 8'd0;
                        end
                    end
                    LOAD: begin
                        shreg_q   <= shreg_d;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            exp_code_q <= shreg_d;
                            wr_pend_q  <= 1'b1;
                            byte_cnt_q <= byte_cnt_d;
                            if (byte_cnt_d == FRAME_LEN_C) begin
                                state_q      <= HUNT;
                                sync_lock_q  <= 1'b0;
                                win_q        <= 8'h00;
                                frame_done_q <= 1'b1;
                            end
                        end
                    end
                endcase
            end
            if (wr_pend_q && fifo_full && !do_pop) begin
                overflow_q <= 1'b1;
            end
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_ONE;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= exp_sample;
        end
    end

    assign exp_code     = exp_code_q;
    assign sample_data  = mem_q[rd_ptr_q];
    assign sample_valid = (count_q != '0);
    assign sync_lock    = sync_lock_q;
    assign frame_done   = frame_done_q;
    assign overflow     = overflow_q;
endmodule

// File: tb/tb_pcm_rx_sequencer.sv
// Bench for pcm_rx_sequencer: bit-level stream model with a sample queue,
// directed frame scenarios plus randomized frames, gaps and consumer stalls.
module tb_pcm_rx_sequencer;
    localparam logic [7:0] SYNC  = 8'h7E;
    localparam int         FLEN  = 4;
    localparam int         DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic [7:0] exp_code;
    logic [7:0] exp_sample;
    logic [7:0] sample_data;
    logic       sample_valid;
    logic       sample_ready;
    logic       sync_lock;
    logic       frame_done;
    logic       overflow;

    always #5 clk = ~clk;

    // Stand-in for the team's 8-bit expander: fixed points from the reference vectors.
    function automatic logic [7:0] expand(input logic [7:0] c);
        case (c)
            8'h35:   expand = 8'h05;
            8'hF0:   expand = 8'hC2;
            8'h00:   expand = 8'h00;
            8'h7F:   expand = 8'h7F;
            default: expand = c ^ 8'h3C;
        endcase
    endfunction

    assign exp_sample = expand(exp_code);

    pcm_rx_sequencer #(.SYNC_WORD(SYNC), .FRAME_LEN(FLEN), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .exp_code(exp_code), .exp_sample(exp_sample),
        .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sync_lock(sync_lock), .frame_done(frame_done), .overflow(overflow)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: stream-level receiver state and the expected sample queue.
    bit         m_locked;
    logic [7:0] m_win, m_sh, m_code;
    int         m_nb, m_nbytes;
    bit         m_pend, m_fd, m_ovf;
    logic [7:0] m_q[$];
    logic [7:0] got_q[$];
    int         rdy_mode;
    int         fd_seen;

    task automatic model_reset();
        m_locked = 0; m_win = 8'h00; m_sh = 8'h00; m_code = 8'h00;
        m_nb = 0; m_nbytes = 0; m_pend = 0; m_fd = 0; m_ovf = 0;
        m_q.delete();
        got_q.delete();
        fd_seen = 0;
    endtask

    task automatic model_step(input bit v, input bit b, input bit r);
        bit full, pop;
        full = (m_q.size() == DEPTH);
        pop  = (m_q.size() != 0) && r;
        if (pop) begin
            got_q.push_back(sample_data);
            void'(m_q.pop_front());
        end
        if (m_pend) begin
            if (!full || pop) m_q.push_back(expand(m_code));
            else m_ovf = 1;
        end
        m_pend = 0;
        m_fd   = 0;
        if (v) begin
            if (!m_locked) begin
                m_win = {m_win[6:0], b};
                if (m_win == SYNC) begin
                    m_locked = 1; m_nb = 0; m_nbytes = 0;
                end
            end else begin
                m_sh = {m_sh[6:0], b};
                m_nb++;
                if (m_nb == 8) begin
                    m_nb = 0; m_code = m_sh; m_pend = 1; m_nbytes++;
                    if (m_nbytes == FLEN) begin
                        m_locked = 0; m_win = 8'h00; m_fd = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("sync_lock", 32'(sync_lock), 32'(m_locked));
        check_eq("frame_done", 32'(frame_done), 32'(m_fd));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("exp_code", 32'(exp_code), 32'(m_code));
        check_eq("sample_valid", 32'(sample_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check_eq("sample_data", 32'(sample_data), 32'(m_q[0]));
        if (frame_done === 1'b1) fd_seen++;
    endtask

    task automatic tick(input bit v, input bit b);
        check_outputs();
        bit_valid = v;
        bit_in    = b;
        case (rdy_mode)
            0:       sample_ready = 1'b1;
            1:       sample_ready = 1'b0;
            2:       sample_ready = 1'($urandom_range(0, 1));
            default: sample_ready = m_pend;
        endcase
        model_step(v, b, sample_ready);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic send_bits(input logic [7:0] val, input int msb, input int lsb, input int gap);
        for (int i = msb; i >= lsb; i--) begin
            repeat ($urandom_range(0, gap)) tick(1'b0, 1'($urandom_range(0, 1)));
            tick(1'b1, val[i]);
        end
    endtask

    task automatic send_byte(input logic [7:0] val, input int gap);
        send_bits(val, 7, 0, gap);
    endtask

    task automatic do_reset();
        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; sample_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_outputs();
    endtask

    logic [7:0] ref_codes [4] = '{8'h35, 8'hF0, 8'h00, 8'h7F};
    logic [7:0] ref_samps [4] = '{8'h05, 8'hC2, 8'h00, 8'h7F};

    task automatic frame_basic(input int gap);
        got_q.delete();
        fd_seen  = 0;
        rdy_mode = 0;
        send_byte(SYNC, gap);
        check_eq("lock_after_sync", 32'(sync_lock), 32'd1);
        for (int i = 0; i < 4; i++) send_byte(ref_codes[i], gap);
        idle(6);
        check_eq("basic_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check_eq("basic_sample", 32'(got_q[i]), 32'(ref_samps[i]));
        check_eq("basic_frame_done_pulses", 32'(fd_seen), 32'd1);
        check_eq("basic_back_to_hunt", 32'(sync_lock), 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] b [4], input int gap);
        send_byte(SYNC, gap);
        for (int i = 0; i < 4; i++) send_byte(b[i], gap);
    endtask

    logic [7:0] fa [4];
    logic [7:0] fb [4];

    initial begin
        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; sample_ready = 1'b0;
        rdy_mode = 0;
        model_reset();

        // Contiguous reference frame.
        do_reset();
        frame_basic(0);

        // Same frame with idle gaps between bits.
        frame_basic(3);

        // Sync embedded after a prefix, then a near-miss pattern.
        do_reset();
        send_bits(8'b1011_0000, 7, 4, 0);
        send_bits(SYNC, 7, 1, 0);
        check_eq("no_lock_before_last_sync_bit", 32'(sync_lock), 32'd0);
        send_bits(SYNC, 0, 0, 0);
        check_eq("lock_on_last_sync_bit", 32'(sync_lock), 32'd1);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1);
        idle(4);
        send_byte(8'h7F, 0);
        idle(3);
        check_eq("near_miss_no_lock", 32'(sync_lock), 32'd0);

        // Consumer stalled across two frames.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            fa[i] = 8'($urandom_range(0, 255));
            fb[i] = 8'($urandom_range(0, 255));
        end
        rdy_mode = 1;
        send_frame(fa, 0);
        send_frame(fb, 0);
        idle(4);
        check_eq("overflow_set", 32'(overflow), 32'd1);
        got_q.delete();
        rdy_mode = 0;
        idle(8);
        check_eq("stall_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check_eq("stall_sample", 32'(got_q[i]), 32'(expand(fa[i])));
        check_eq("overflow_sticky", 32'(overflow), 32'd1);

        // Full FIFO with a pop in every push cycle.
        do_reset();
        rdy_mode = 1;
        send_frame(fa, 0);
        idle(3);
        check_eq("full_before", 32'(sample_valid), 32'd1);
        got_q.delete();
        rdy_mode = 3;
        send_frame(fb, 1);
        idle(3);
        check_eq("full_no_overflow", 32'(overflow), 32'd0);
        check_eq("full_pops", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check_eq("full_pop_sample", 32'(got_q[i]), 32'(expand(fa[i])));
        got_q.delete();
        rdy_mode = 0;
        idle(8);
        check_eq("full_drain_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check_eq("full_drain_sample", 32'(got_q[i]), 32'(expand(fb[i])));

        // Reset in the middle of byte 2.
        do_reset();
        rdy_mode = 1;
        send_byte(SYNC, 0);
        send_byte(fa[0], 0);
        send_bits(fa[1], 7, 3, 0);
        do_reset();
        check_eq("rst_fifo_empty", 32'(sample_valid), 32'd0);
        check_eq("rst_code", 32'(exp_code), 32'd0);
        rdy_mode = 0;
        idle(4);
        frame_basic(0);

        // Randomized traffic with noise, gaps and a random consumer.
        do_reset();
        for (int f = 0; f < 12; f++) begin
            rdy_mode = 2;
            for (int n = $urandom_range(0, 10); n > 0; n--) tick(1'b1, 1'($urandom_range(0, 1)));
            for (int i = 0; i < 4; i++) fa[i] = 8'($urandom_range(0, 255));
            send_frame(fa, $urandom_range(0, 3));
            idle($urandom_range(0, 6));
        end
        rdy_mode = 0;
        idle(20);
        check_eq("random_drained", 32'(sample_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
